// File: rtl/sha256_iter_core_if.sv
// rtl/sha256_iter_core_if.sv - block-in / digest-out handshake bundle for sha256_iter_core
// Optional in_mode_224 signal exists only when SHA224_MODE_EN is defined.
interface sha256_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [511:0] in_block;
`ifdef SHA224_MODE_EN
    logic         in_mode_224;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;
    logic         busy;

`ifdef SHA224_MODE_EN
    modport master (output in_valid, in_first, in_block, in_mode_224, out_ready,
                    input  in_ready, out_valid, out_digest, busy);
    modport slave  (input  in_valid, in_first, in_block, in_mode_224, out_ready,
                    output in_ready, out_valid, out_digest, busy);
`else
    modport master (output in_valid, in_first, in_block, out_ready,
                    input  in_ready, out_valid, out_digest, busy);
    modport slave  (input  in_valid, in_first, in_block, out_ready,
                    output in_ready, out_valid, out_digest, busy);
`endif
endinterface

// File: rtl/sha256_iter_core.sv
// rtl/sha256_iter_core.sv - multi-block SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clk
// Optional SHA-224 IV/truncation enabled by defining SHA224_MODE_EN.
module sha256_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    sha256_iter_core_if.slave bus
);
    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_RND = 6'(64 - R);
    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [255:0] iv_of(input logic m224);
        return m224 ? IV224 : IV256;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   w_q [16];
    logic [31:0]   wk_q [8];
    logic [5:0]    rnd_q;
    logic          first_q;
    logic [255:0]  digest_q;
    logic          accept;
    logic          mode_q;
    logic          mode_in;

    logic [31:0]   ext [16+R];
    logic [31:0]   wk [R+1][8];
    logic [31:0]   t1 [R];
    logic [31:0]   t2 [R];
    logic [255:0]  start_base, fin_base, new_digest;

`ifdef SHA224_MODE_EN
    assign mode_in = bus.in_mode_224;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        mode_q <= 1'b0;
        else if (accept && bus.in_first)   mode_q <= mode_in;
    end
`else
    assign mode_in = 1'b0;
    assign mode_q  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: if (rnd_q == LAST_RND) state_d = S_FINAL;
            S_FINAL: state_d = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Window always holds W[rnd..rnd+15]; ext[16+k] extends it by R words for this edge.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w_q[i];
        for (int k = 0; k < R; k++)
            ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
        for (int i = 0; i < 8; i++) wk[0][i] = wk_q[i];
        for (int j = 0; j < R; j++) begin
            t1[j] = wk[j][7] + bsig1(wk[j][4]) + ((wk[j][4] & wk[j][5]) ^ (~wk[j][4] & wk[j][6]))
                  + K[rnd_q + 6'(j)] + ext[j];
            t2[j] = bsig0(wk[j][0]) + ((wk[j][0] & wk[j][1]) ^ (wk[j][0] & wk[j][2]) ^ (wk[j][1] & wk[j][2]));
            wk[j+1][0] = t1[j] + t2[j];
            wk[j+1][1] = wk[j][0];
            wk[j+1][2] = wk[j][1];
            wk[j+1][3] = wk[j][2];
            wk[j+1][4] = wk[j][3] + t1[j];
            wk[j+1][5] = wk[j][4];
            wk[j+1][6] = wk[j][5];
            wk[j+1][7] = wk[j][6];
        end
    end

    always_comb begin
        start_base = bus.in_first ? iv_of(mode_in) : digest_q;
        fin_base   = first_q ? iv_of(mode_q) : digest_q;
        for (int i = 0; i < 8; i++)
            new_digest[255-32*i -: 32] = fin_base[255-32*i -: 32] + wk_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            for (int i = 0; i < 8; i++)  wk_q[i] <= '0;
            rnd_q    <= '0;
            first_q  <= 1'b0;
            digest_q <= IV256;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) w_q[i] <= bus.in_block[511-32*i -: 32];
            for (int i = 0; i < 8; i++)  wk_q[i] <= start_base[255-32*i -: 32];
            rnd_q   <= '0;
            first_q <= bus.in_first;
        end else if (state_q == S_ROUND) begin
            for (int i = 0; i < 16; i++) w_q[i] <= ext[R+i];
            for (int i = 0; i < 8; i++)  wk_q[i] <= wk[R][i];
            rnd_q <= rnd_q + 6'(R);
        end else if (state_q == S_FINAL) begin
            digest_q <= new_digest;
        end
    end

    // SHA-224 truncation is applied only at the output; digest_q keeps H7 for chaining.
    assign bus.out_digest = mode_q ? {digest_q[255:32], 32'h0} : digest_q;
endmodule

// File: tb/tb_sha256_iter_core.sv
// tb/tb_sha256_iter_core.sv - directed-vector bench for sha256_iter_core, one instance per legal R
// Exercises SHA224_MODE_EN vectors when that macro is defined.
module tb_sha256_iter_core;
    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vld = 1'b0;
    logic         first = 1'b0;
    logic         ordy = 1'b0;
    logic [511:0] blk = '0;
    logic [4:0]   en = 5'b00001;
    logic [4:0]   irdy, ovld, bsy;
    logic [255:0] dig [5];
`ifdef SHA224_MODE_EN
    logic         m224 = 1'b0;
`endif

    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sha256_iter_core_if bus ();
        assign bus.in_valid  = vld & en[g];
        assign bus.in_first  = first;
        assign bus.in_block  = blk;
        assign bus.out_ready = ordy;
`ifdef SHA224_MODE_EN
        assign bus.in_mode_224 = m224;
`endif
        assign irdy[g] = bus.in_ready;
        assign ovld[g] = bus.out_valid;
        assign bsy[g]  = bus.busy;
        assign dig[g]  = bus.out_digest;
        sha256_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] b, input logic f, input logic [4:0] m);
        int w = 0;
        while (((irdy & m) != m) && w < 200) begin
            tick();
            w++;
        end
        check("ready_before_send", 256'(irdy & m), 256'(m));
        blk = b; first = f; en = m; vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic wait_out(input int idx, output int lat);
        lat = 0;
        while (!ovld[idx] && lat < 200) begin
            tick();
            lat++;
        end
        if (!ovld[idx]) lat = -1;
    endtask

    logic [511:0] b_abc, b_empty, b_two1, b_two2;
    int lat;
    int lats [5];

    initial begin
        b_abc   = {32'h61626380, 448'h0, 32'h00000018};
        b_empty = {32'h80000000, 480'h0};
        b_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        b_two2  = {480'h0, 32'h000001c0};

        // reset state
        tick(); tick();
        check("rst_out_valid", 256'(ovld[0]), 256'(0));
        check("rst_busy", 256'(bsy[0]), 256'(0));
        check("rst_digest", dig[0], IV256);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 256'(irdy), 256'(5'b11111));

        // "abc", R=1, then back-pressure hold in DONE
        ordy = 1'b0;
        send(b_abc, 1'b1, 5'b00001);
        wait_out(0, lat);
        check("abc_latency", 256'(lat), 256'(65));
        check("abc_digest", dig[0], D_ABC);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", 256'(ovld[0]), 256'(1));
            check("hold_digest", dig[0], D_ABC);
            check("hold_in_ready", 256'(irdy[0]), 256'(0));
        end
        ordy = 1'b1;
        tick();
        check("handoff_idle", 256'(bsy[0]), 256'(0));

        // empty message on every R; latency N+1
        ordy = 1'b0;
        send(b_empty, 1'b1, 5'b11111);
        for (int g = 0; g < 5; g++) lats[g] = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            for (int g = 0; g < 5; g++)
                if (ovld[g] && lats[g] == 0) lats[g] = c;
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("empty_latency_r%0d", 1 << g), 256'(lats[g]), 256'(64 / (1 << g) + 1));
            check($sformatf("empty_digest_r%0d", 1 << g), dig[g], D_EMPTY);
        end
        ordy = 1'b1;
        tick();

        // two-block message with stray in_valid pulses during ROUND
        send(b_two1, 1'b1, 5'b00001);
        wait_out(0, lat);
        check("two_blk1_latency", 256'(lat), 256'(65));
        send(b_two2, 1'b0, 5'b00001);
        for (int p = 0; p < 3; p++) begin
            tick(); tick(); tick();
            blk = b_empty; first = 1'b1; vld = 1'b1;
            check("round_in_ready", 256'(irdy[0]), 256'(0));
            tick();
            vld = 1'b0;
        end
        wait_out(0, lat);
        check("two_digest", dig[0], D_TWO);
        tick();

        // reset at rnd=32, then chain from the reset IV
        send(b_abc, 1'b1, 5'b00001);
        for (int i = 0; i < 32; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 256'(ovld[0]), 256'(0));
        check("midrst_busy", 256'(bsy[0]), 256'(0));
        check("midrst_digest", dig[0], IV256);
        tick();
        rst_n = 1'b1;
        tick();
        send(b_abc, 1'b0, 5'b00001);
        wait_out(0, lat);
        check("midrst_latency", 256'(lat), 256'(65));
        check("midrst_digest_after", dig[0], D_ABC);
        tick();

`ifdef SHA224_MODE_EN
        m224 = 1'b1;
        send(b_abc, 1'b1, 5'b00001);
        m224 = 1'b0;
        wait_out(0, lat);
        check("sha224_digest", dig[0],
              {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0});
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
